// File: rtl/raw_tr_freq_counter_if.sv
// raw_tr_freq_counter_if
//   Control/readout bundle for the gated edge counter.
//   master: drives ena, start, gate_sel, cont, sig_in, byte_sel; reads results
//   slave : the counter itself; drives dout, busy, done, ovf
interface raw_tr_freq_counter_if;
  logic       ena;
  logic       start;
  logic [2:0] gate_sel;
  logic       cont;
  logic       sig_in;
  logic       byte_sel;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (
    output ena, start, gate_sel, cont, sig_in, byte_sel,
    input  dout, busy, done, ovf
  );

  modport slave (
    input  ena, start, gate_sel, cont, sig_in, byte_sel,
    output dout, busy, done, ovf
  );
endinterface

// File: rtl/raw_tr_freq_counter.sv
// raw_tr_freq_counter
//   Gated edge counter for the raw-transistor test structures. Counts rising
//   edges of the asynchronous sig_in over a window of (256 << gate_sel) clk
//   cycles and holds the count in a result register read out a byte at a time.
// Ports
//   clk    : system clock, all state on rising edge
//   rst_n  : asynchronous active-low reset, clears all state
//   bus    : raw_tr_freq_counter_if.slave
//            in : ena, start, gate_sel[2:0], cont, sig_in, byte_sel
//            out: dout[7:0], busy, done, ovf
// Parameters
//   COUNT_W : result width, 9..16
// Build option
//   RAWTR_CONT_MODE_EN : when defined, cont=1 re-arms a new window straight
//                        from LATCH; otherwise cont is ignored.
module raw_tr_freq_counter #(
  parameter int COUNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  raw_tr_freq_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t             state, state_nxt;
  logic               sig_meta, sig_sync, sig_prev, start_q;
  logic               rise, st_rise;
  logic               accept, rearm;
  logic [14:0]        gate_cnt;
  logic [COUNT_W-1:0] count, result;
  logic               ovf_acc, ovf_q, done_q;
  logic [15:0]        res_ext;

  // Last index of a window: (256 << g) - 1, i.e. the low 8+g bits set.
  function automatic logic [14:0] win_last(input logic [2:0] g);
    return 15'h7fff >> (3'd7 - g);
  endfunction

  // Input conditioning: 2-flop synchronizer on sig_in, edge detects.
  // sig_prev follows sig_sync every cycle, so a level already high when the
  // window opens never looks like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_meta <= 1'b0;
      sig_sync <= 1'b0;
      sig_prev <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      sig_meta <= bus.sig_in;
      sig_sync <= sig_meta;
      sig_prev <= sig_sync;
      start_q  <= bus.start;
    end
  end

  assign rise    = sig_sync & ~sig_prev;
  assign st_rise = bus.start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rearm     = 1'b0;
    if (!bus.ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (st_rise) begin
                 accept    = 1'b1;
                 state_nxt = ARM;
               end
        ARM:   state_nxt = GATE;
        GATE:  if (gate_cnt == '0) state_nxt = LATCH;
        LATCH: begin
`ifdef RAWTR_CONT_MODE_EN
                 if (bus.cont) begin
                   rearm     = 1'b1;
                   state_nxt = ARM;
                 end else begin
                   state_nxt = IDLE;
                 end
`else
                 state_nxt = IDLE;
`endif
               end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef RAWTR_CONT_MODE_EN
  logic [2:0] gsel_q;  // window length reused on every re-arm

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      gsel_q <= '0;
    else if (accept) gsel_q <= bus.gate_sel;
  end
`else
  logic unused_cont;
  assign unused_cont = bus.cont;
`endif

  // Datapath. Everything is qualified by ena (through accept/state_nxt or
  // explicitly) so an abort leaves result/ovf/done untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      count    <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (accept) begin
      gate_cnt <= win_last(bus.gate_sel);
      count    <= '0;
      ovf_acc  <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.ena && state == GATE) begin
      gate_cnt <= gate_cnt - 15'd1;
      if (rise) begin
        if (&count) ovf_acc <= 1'b1;
        else        count   <= count + 1'b1;
      end
    end else if (bus.ena && state == LATCH) begin
      result <= count;
      ovf_q  <= ovf_acc;
      done_q <= 1'b1;
`ifdef RAWTR_CONT_MODE_EN
      if (rearm) begin
        gate_cnt <= win_last(gsel_q);
        count    <= '0;
        ovf_acc  <= 1'b0;
      end
`endif
    end
  end

  assign res_ext  = 16'(result);
  assign bus.dout = bus.byte_sel ? res_ext[15:8] : res_ext[7:0];
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule
